// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and FSM states.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu on latched operands.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo,
  output logic             div_by_zero
);

  logic                 is_signed;
  logic                 sign_a;
  logic                 sign_b;
  logic [2*WIDTH-1:0]   ext_a;
  logic [2*WIDTH-1:0]   ext_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     div_b;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  // Signed divide works on magnitudes and restores signs afterwards; min_int / -1
  // falls out naturally as quotient min_int, remainder 0.
  always_comb begin
    is_signed   = (op == MDU_MULT) || (op == MDU_DIV);
    sign_a      = is_signed & a[WIDTH-1];
    sign_b      = is_signed & b[WIDTH-1];
    ext_a       = {{WIDTH{sign_a}}, a};
    ext_b       = {{WIDTH{sign_b}}, b};
    prod        = ext_a * ext_b;
    mag_a       = sign_a ? -a : a;
    mag_b       = sign_b ? -b : b;
    div_by_zero = is_div(op) && (b == '0);
    div_b       = (b == '0) ? WIDTH'(1) : mag_b;
    quo         = mag_a / div_b;
    rem         = mag_a % div_b;
    quo_s       = (sign_a ^ sign_b) ? -quo : quo;
    rem_s       = sign_a ? -rem : rem;
    next_hi     = '0;
    next_lo     = '0;
    case (op)
      MDU_MULT, MDU_MULTU: {next_hi, next_lo} = prod;
      MDU_DIV, MDU_DIVU: begin
        next_hi = rem_s;
        next_lo = quo_s;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy holds off dependent ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;
  logic             div_by_zero;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .next_hi     (next_hi),
    .next_lo     (next_lo),
    .div_by_zero (div_by_zero)
  );

  // busy mirrors RUN, so a start is only ever seen while IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              MDU_MTHI: hi <= a;
              MDU_MTLO: lo <= a;
              MDU_MULT, MDU_MULTU: begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
                cnt   <= CW'(MULT_CYCLES - 1);
                busy  <= 1'b1;
                state <= RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
                cnt   <= CW'(DIV_CYCLES - 1);
                busy  <= 1'b1;
                state <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Divide by zero still completes with done, but leaves HI/LO untouched.
            if (!div_by_zero) begin
              hi <= next_hi;
              lo <= next_lo;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Randomised scoreboard bench for mdu against a plain-arithmetic HI/LO model.
module tb_mdu;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef struct {
    int           cyc;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           pulse;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           cyc;
  int           vectors;
  int           miscompares;
  int           busy_start;
  int           busy_end;
  logic [W-1:0] hi_m;
  logic [W-1:0] lo_m;
  exp_t         q[$];

  mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_busy(input int c);
    return (c >= busy_start) && (c < busy_end);
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom % 6)
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Called at a falling edge; the start is sampled by the following rising edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int          c;
    int          sx;
    int          sy;
    longint      ps;
    logic [63:0] pu;
    exp_t        e;
    c     = cyc;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (!exp_busy(c) && o <= OP_MTLO) begin
      e.pulse = (o <= OP_DIVU);
      e.cyc   = c + 1;
      case (o)
        OP_MTHI: hi_m = x;
        OP_MTLO: lo_m = x;
        OP_MULT: begin
          sx = x;
          sy = y;
          ps = longint'(sx) * longint'(sy);
          pu = ps;
          {hi_m, lo_m} = pu;
        end
        OP_MULTU: begin
          pu = {32'b0, x} * {32'b0, y};
          {hi_m, lo_m} = pu;
        end
        OP_DIV: begin
          if (y != 0) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
              lo_m = x;
              hi_m = '0;
            end else begin
              sx   = x;
              sy   = y;
              lo_m = sx / sy;
              hi_m = sx % sy;
            end
          end
        end
        default: begin
          if (y != 0) begin
            lo_m = x / y;
            hi_m = x % y;
          end
        end
      endcase
      if (e.pulse) begin
        busy_start = c + 1;
        busy_end   = c + 1 + ((o <= OP_MULTU) ? MC : DC);
        e.cyc      = busy_end;
      end
      e.hi = hi_m;
      e.lo = lo_m;
      q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Operands are scrambled while waiting to show they are not re-sampled in RUN.
  task automatic wait_idle();
    while (exp_busy(cyc)) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
  endtask

  // Monitor: checks busy every cycle and pops the scoreboard on done or on the due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("busy", W'(busy), W'(exp_busy(cyc)));
        if (done) begin
          if (q.size() == 0 || !q[0].pulse || q[0].cyc != cyc) begin
            chk("unexpected done", W'(done), '0);
          end else begin
            e = q.pop_front();
            chk("done hi", hi, e.hi);
            chk("done lo", lo, e.lo);
          end
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          if (e.pulse) begin
            chk("done pulse", W'(done), W'(1));
          end else begin
            chk("mt hi", hi, e.hi);
            chk("mt lo", lo, e.lo);
            chk("mt busy", W'(busy), '0);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    busy_start  = 0;
    busy_end    = 0;
    hi_m        = '0;
    lo_m        = '0;
    reset       = 1'b0;
    start       = 1'b0;
    op          = '0;
    a           = '0;
    b           = '0;
    #1;
    chk("reset hi", hi, '0);
    chk("reset lo", lo, '0);
    chk("reset busy", W'(busy), '0);
    chk("reset done", W'(done), '0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2);
    wait_idle();
    chk("mult hi", hi, 32'hFFFF_FFFF);
    chk("mult lo", lo, 32'hFFFF_FFFE);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_idle();
    chk("multu hi", hi, 32'h1);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_idle();
    chk("div lo", lo, 32'hFFFF_FFFD);
    chk("div hi", hi, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("div ovf lo", lo, 32'h8000_0000);
    chk("div ovf hi", hi, '0);

    issue(OP_MTHI, 32'h1111_1111, '0);
    issue(OP_MTLO, 32'h2222_2222, '0);
    issue(OP_DIVU, 32'h7, '0);
    wait_idle();
    chk("div0 hi", hi, 32'h1111_1111);
    chk("div0 lo", lo, 32'h2222_2222);

    issue(OP_MULT, 32'h3, 32'h5);
    @(negedge clk);
    issue(OP_MTLO, 32'hDEAD_BEEF, '0);
    wait_idle();
    chk("ignored mtlo", lo, 32'hF);

    issue(OP_DIV, 32'h64, 32'h7);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort hi", hi, '0);
    chk("abort lo", lo, '0);
    chk("abort busy", W'(busy), '0);
    chk("abort done", W'(done), '0);
    q.delete();
    hi_m       = '0;
    lo_m       = '0;
    busy_start = 0;
    busy_end   = 0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    issue(OP_MULT, 32'h3, 32'h4);
    wait_idle();
    chk("post reset lo", lo, 32'hC);

    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 != 0) wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard drained", W'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
